// File: rtl/uart_pkg.sv
// Shared definitions for the framed UART transmitter: FSM state encodings,
// parity-mode codes and the parity helper.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    // Data is zero-extended to 9 bits, so unused upper bits do not disturb the XOR.
    function automatic logic calc_parity(input logic [8:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Show-ahead transmit FIFO: the head word is always visible on rd_data,
// and the count, full and empty flags are all held in registers.
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     sysclk_in,
    input  logic                     nrst_in,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_nxt_s;
    logic             full_r;
    logic             empty_r;
    logic             wr_acc_s;
    logic             pop_acc_s;

    assign wr_acc_s  = wr_en && !full_r;
    assign pop_acc_s = pop && !empty_r;

    // Next occupancy; a simultaneous write and pop leaves it unchanged.
    always_comb begin
        count_nxt_s = count_r;
        case ({wr_acc_s, pop_acc_s})
            2'b10:   count_nxt_s = count_r + CNT_W'(1);
            2'b01:   count_nxt_s = count_r - CNT_W'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Storage array; contents become irrelevant once the pointers are reset.
    always_ff @(posedge sysclk_in) begin
        if (wr_acc_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers (power-of-two depth wraps naturally) and status flags.
    always_ff @(posedge sysclk_in or negedge nrst_in) begin
        if (!nrst_in) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (wr_acc_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_acc_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r <= count_nxt_s;
            full_r  <= (count_nxt_s == CNT_W'(DEPTH));
            empty_r <= (count_nxt_s == {CNT_W{1'b0}});
        end
    end

    assign rd_data = mem_r[rd_ptr_r];
    assign full    = full_r;
    assign empty   = empty_r;
    assign count   = count_r;

endmodule

// File: rtl/uart_tx_framed.sv
// UART transmitter with a write FIFO, optional even/odd parity and one or two
// stop bits; each bit spans OVERSAMPLING baud strobes.
module uart_tx_framed
    import uart_pkg::*;
#(
    parameter int OVERSAMPLING = 8,
    parameter int DATA_BITS    = 8,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          sysclk_in,
    input  logic                          nrst_in,
    input  logic                          baudpulse_in,
    input  logic                          tx_valid_in,
    input  logic [DATA_BITS-1:0]          tx_data_in,
    input  logic [1:0]                    parity_mode_in,
    input  logic                          stop2_in,
    output logic                          tx_ready_out,
    output logic                          tx_serial_out,
    output logic                          tx_busy_out,
    output logic                          tx_done_out,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_out
);

    localparam int TICK_W = $clog2(OVERSAMPLING);
    localparam int BIT_W  = $clog2(DATA_BITS);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLING - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    tx_state_t              state_r;
    logic [TICK_W-1:0]      tick_r;
    logic [BIT_W-1:0]       bit_r;
    logic [DATA_BITS-1:0]   shift_r;
    logic                   par_en_r;
    logic                   par_bit_r;
    logic                   stop2_r;
    logic                   serial_r;
    logic                   busy_r;
    logic                   done_r;

    logic [DATA_BITS-1:0]   fifo_rd_s;
    logic                   fifo_full_s;
    logic                   fifo_empty_s;
    logic                   pop_s;
    logic                   bit_end_s;
    logic                   last_stop_s;

    uart_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .sysclk_in (sysclk_in),
        .nrst_in   (nrst_in),
        .wr_en     (tx_valid_in),
        .wr_data   (tx_data_in),
        .pop       (pop_s),
        .rd_data   (fifo_rd_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .count     (fifo_count_out)
    );

    // Bit-boundary detection and FIFO pop decision (from IDLE, or chained after the last stop bit).
    always_comb begin
        bit_end_s   = baudpulse_in && (tick_r == TICK_LAST);
        last_stop_s = !stop2_r || (bit_r == BIT_W'(1));
        pop_s       = 1'b0;
        if (!fifo_empty_s) begin
            if (state_r == ST_IDLE) begin
                pop_s = baudpulse_in;
            end else if (state_r == ST_STOP) begin
                pop_s = bit_end_s && last_stop_s;
            end else begin
                pop_s = 1'b0;
            end
        end else begin
            pop_s = 1'b0;
        end
    end

    // Frame FSM with registered line, busy and done outputs.
    always_ff @(posedge sysclk_in or negedge nrst_in) begin
        if (!nrst_in) begin
            state_r   <= ST_IDLE;
            tick_r    <= {TICK_W{1'b0}};
            bit_r     <= {BIT_W{1'b0}};
            shift_r   <= {DATA_BITS{1'b0}};
            par_en_r  <= 1'b0;
            par_bit_r <= 1'b0;
            stop2_r   <= 1'b0;
            serial_r  <= 1'b1;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            done_r <= (state_r == ST_STOP) && bit_end_s && last_stop_s;
            if (pop_s) begin
                // Frame settings are captured here and held until the frame ends.
                shift_r   <= fifo_rd_s;
                par_en_r  <= (parity_mode_in == PAR_EVEN) || (parity_mode_in == PAR_ODD);
                par_bit_r <= calc_parity(9'(fifo_rd_s), parity_mode_in == PAR_ODD);
                stop2_r   <= stop2_in;
                serial_r  <= 1'b0;
                busy_r    <= 1'b1;
                tick_r    <= {TICK_W{1'b0}};
                bit_r     <= {BIT_W{1'b0}};
                state_r   <= ST_START;
            end else begin
                if (baudpulse_in && (state_r != ST_IDLE)) begin
                    tick_r <= bit_end_s ? {TICK_W{1'b0}} : tick_r + TICK_W'(1);
                end
                case (state_r)
                    ST_IDLE: begin
                        serial_r <= 1'b1;
                        busy_r   <= 1'b0;
                    end
                    ST_START: begin
                        if (bit_end_s) begin
                            serial_r <= shift_r[0];
                            bit_r    <= {BIT_W{1'b0}};
                            state_r  <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        if (bit_end_s) begin
                            if (bit_r == BIT_LAST) begin
                                bit_r <= {BIT_W{1'b0}};
                                if (par_en_r) begin
                                    serial_r <= par_bit_r;
                                    state_r  <= ST_PARITY;
                                end else begin
                                    serial_r <= 1'b1;
                                    state_r  <= ST_STOP;
                                end
                            end else begin
                                bit_r    <= bit_r + BIT_W'(1);
                                shift_r  <= shift_r >> 1;
                                serial_r <= shift_r[1];
                            end
                        end
                    end
                    ST_PARITY: begin
                        if (bit_end_s) begin
                            serial_r <= 1'b1;
                            state_r  <= ST_STOP;
                        end
                    end
                    ST_STOP: begin
                        if (bit_end_s) begin
                            if (last_stop_s) begin
                                serial_r <= 1'b1;
                                busy_r   <= 1'b0;
                                bit_r    <= {BIT_W{1'b0}};
                                state_r  <= ST_IDLE;
                            end else begin
                                bit_r <= bit_r + BIT_W'(1);
                            end
                        end
                    end
                    default: begin
                        serial_r <= 1'b1;
                        busy_r   <= 1'b0;
                        state_r  <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign tx_ready_out  = !fifo_full_s;
    assign tx_serial_out = serial_r;
    assign tx_busy_out   = busy_r;
    assign tx_done_out   = done_r;

endmodule

// File: tb/tb_uart_tx_framed.sv
// Scoreboard bench for uart_tx_framed: written words are queued with their
// frame settings and a line monitor compares every strobe against a bit model.
`timescale 1ns/1ps
module tb_uart_tx_framed;

    localparam int OS = 4;

    logic       sysclk_in = 1'b0;
    logic       nrst_in;
    logic       baudpulse_in;
    logic       tx_valid_in;
    logic [7:0] tx_data_in;
    logic [1:0] parity_mode_in;
    logic       stop2_in;
    logic       tx_ready_out;
    logic       tx_serial_out;
    logic       tx_busy_out;
    logic       tx_done_out;
    logic [2:0] fifo_count_out;

    typedef struct {
        logic [7:0] data;
        logic [1:0] mode;
        logic       stop2;
    } frame_t;

    frame_t sb[$];
    int     checks = 0;
    int     failures = 0;
    bit     baud_en = 1'b0;
    int     baud_cnt = 0;
    bit     mon_active = 1'b0;
    int     mon_k = 0;
    int     mon_nbits = 0;
    logic   mon_bits [12];
    int     frames_done = 0;
    int     done_seen = 0;
    int     last_len = 0;
    logic   last_bit9 = 1'b0;

    uart_tx_framed #(
        .OVERSAMPLING (4),
        .DATA_BITS    (8),
        .FIFO_DEPTH   (4)
    ) dut (
        .sysclk_in      (sysclk_in),
        .nrst_in        (nrst_in),
        .baudpulse_in   (baudpulse_in),
        .tx_valid_in    (tx_valid_in),
        .tx_data_in     (tx_data_in),
        .parity_mode_in (parity_mode_in),
        .stop2_in       (stop2_in),
        .tx_ready_out   (tx_ready_out),
        .tx_serial_out  (tx_serial_out),
        .tx_busy_out    (tx_busy_out),
        .tx_done_out    (tx_done_out),
        .fifo_count_out (fifo_count_out)
    );

    always #5 sysclk_in = ~sysclk_in;

    task automatic build_bits(input frame_t f);
        int n;
        mon_bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) mon_bits[1 + i] = f.data[i];
        n = 9;
        if (f.mode == 2'b01) begin
            mon_bits[n] = ^f.data;
            n++;
        end else if (f.mode == 2'b10) begin
            mon_bits[n] = ~^f.data;
            n++;
        end
        mon_bits[n] = 1'b1;
        n++;
        if (f.stop2) begin
            mon_bits[n] = 1'b1;
            n++;
        end
        mon_nbits = n;
    endtask

    task automatic mon_start();
        frame_t f;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL unexpected_frame: line went low with no word queued");
            mon_active = 1'b0;
        end else begin
            f = sb.pop_front();
            build_bits(f);
            mon_active = 1'b1;
            mon_k = 0;
        end
    endtask

    task automatic mon_strobe();
        logic exp_line;
        if (!mon_active) begin
            if (tx_serial_out === 1'b0) mon_start();
        end else begin
            mon_k++;
            if (mon_k == 9 * OS + 1) last_bit9 = tx_serial_out;
            if (mon_k < mon_nbits * OS) begin
                checks++;
                if (tx_serial_out !== mon_bits[mon_k / OS] || tx_done_out !== 1'b0 || tx_busy_out !== 1'b1) begin
                    failures++;
                    $display("FAIL frame_bit strobe=%0d: got line=%b done=%b busy=%b, expected line=%b done=0 busy=1",
                             mon_k, tx_serial_out, tx_done_out, tx_busy_out, mon_bits[mon_k / OS]);
                end
            end else begin
                exp_line = (sb.size() == 0);
                checks++;
                if (tx_done_out !== 1'b1 || tx_serial_out !== exp_line || tx_busy_out !== !exp_line) begin
                    failures++;
                    $display("FAIL frame_end strobe=%0d: got done=%b line=%b busy=%b, expected done=1 line=%b busy=%b",
                             mon_k, tx_done_out, tx_serial_out, tx_busy_out, exp_line, !exp_line);
                end
                last_len = mon_k;
                frames_done++;
                mon_active = 1'b0;
                if (tx_serial_out === 1'b0) mon_start();
            end
        end
    endtask

    task automatic mon_cycle();
        if (tx_done_out === 1'b1) done_seen++;
        checks++;
        if ((!baudpulse_in && tx_done_out !== 1'b0) ||
            (!mon_active && (tx_serial_out !== 1'b1 || tx_busy_out !== 1'b0))) begin
            failures++;
            $display("FAIL idle_or_stray: got line=%b busy=%b done=%b strobe=%b active=%0d",
                     tx_serial_out, tx_busy_out, tx_done_out, baudpulse_in, mon_active);
        end
    endtask

    // Baud strobe generator (one strobe every 3 clocks) and line monitor.
    initial begin
        baudpulse_in = 1'b0;
        forever begin
            @(negedge sysclk_in);
            if (nrst_in !== 1'b1) begin
                mon_active = 1'b0;
                sb.delete();
            end else begin
                if (baudpulse_in) mon_strobe();
                mon_cycle();
            end
            baud_cnt = (baud_cnt == 2) ? 0 : baud_cnt + 1;
            baudpulse_in = baud_en && (baud_cnt == 0);
        end
    end

    task automatic write_word(input logic [7:0] d, input bit exp_acc, input string nm);
        frame_t f;
        @(negedge sysclk_in);
        tx_data_in = d;
        tx_valid_in = 1'b1;
        checks++;
        if (tx_ready_out !== exp_acc) begin
            failures++;
            $display("FAIL %s_ready: got %b expected %b", nm, tx_ready_out, exp_acc);
        end
        @(posedge sysclk_in);
        #1;
        tx_valid_in = 1'b0;
        if (exp_acc) begin
            f.data = d;
            f.mode = parity_mode_in;
            f.stop2 = stop2_in;
            sb.push_back(f);
        end
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while ((sb.size() != 0 || mon_active || tx_busy_out !== 1'b0) && n < 3000) begin
            @(negedge sysclk_in);
            n++;
        end
        checks++;
        if (n >= 3000) begin
            failures++;
            $display("FAIL %s_timeout: got queued=%0d busy=%b expected idle", nm, sb.size(), tx_busy_out);
        end
        repeat (4) @(negedge sysclk_in);
    endtask

    task automatic test_reset();
        tx_valid_in = 1'b0;
        tx_data_in = 8'h00;
        parity_mode_in = 2'b00;
        stop2_in = 1'b0;
        nrst_in = 1'b1;
        #3;
        nrst_in = 1'b0;
        #4;
        checks++;
        if (tx_serial_out !== 1'b1 || tx_busy_out !== 1'b0 || tx_done_out !== 1'b0 ||
            tx_ready_out !== 1'b1 || fifo_count_out !== 3'd0) begin
            failures++;
            $display("FAIL reset_state: got line=%b busy=%b done=%b ready=%b count=%0d expected 1 0 0 1 0",
                     tx_serial_out, tx_busy_out, tx_done_out, tx_ready_out, fifo_count_out);
        end
        repeat (2) @(negedge sysclk_in);
        nrst_in = 1'b1;
        baud_en = 1'b1;
        repeat (3) @(negedge sysclk_in);
    endtask

    task automatic test_basic();
        int d0 = done_seen;
        parity_mode_in = 2'b00;
        stop2_in = 1'b0;
        write_word(8'hA5, 1'b1, "basic");
        wait_idle("basic");
        checks++;
        if (last_len !== 40 || done_seen - d0 !== 1) begin
            failures++;
            $display("FAIL basic_len: got strobes=%0d done_pulses=%0d expected 40 1", last_len, done_seen - d0);
        end
    endtask

    task automatic test_parity();
        parity_mode_in = 2'b01;
        write_word(8'h07, 1'b1, "par_even");
        wait_idle("par_even");
        checks++;
        if (last_bit9 !== 1'b1 || last_len !== 44) begin
            failures++;
            $display("FAIL par_even_bit: got parity=%b strobes=%0d expected 1 44", last_bit9, last_len);
        end
        parity_mode_in = 2'b10;
        write_word(8'h07, 1'b1, "par_odd");
        wait_idle("par_odd");
        checks++;
        if (last_bit9 !== 1'b0 || last_len !== 44) begin
            failures++;
            $display("FAIL par_odd_bit: got parity=%b strobes=%0d expected 0 44", last_bit9, last_len);
        end
        parity_mode_in = 2'b11;
        write_word(8'hC6, 1'b1, "par_11");
        wait_idle("par_11");
        checks++;
        if (last_len !== 40) begin
            failures++;
            $display("FAIL par_11_len: got strobes=%0d expected 40", last_len);
        end
        parity_mode_in = 2'b00;
    endtask

    task automatic test_stop2();
        int n = 0;
        stop2_in = 1'b1;
        write_word(8'h00, 1'b1, "stop2");
        while (!(mon_active && mon_k >= 10) && n < 500) begin
            @(negedge sysclk_in);
            n++;
        end
        stop2_in = 1'b0;
        parity_mode_in = 2'b01;
        wait_idle("stop2");
        checks++;
        if (last_len !== 44 || n >= 500) begin
            failures++;
            $display("FAIL stop2_len: got strobes=%0d expected 44", last_len);
        end
        parity_mode_in = 2'b00;
    endtask

    task automatic test_fifo_full();
        logic [7:0] vals [4];
        int f0 = frames_done;
        vals[0] = 8'h3C; vals[1] = 8'hC3; vals[2] = 8'h5A; vals[3] = 8'h81;
        baud_en = 1'b0;
        repeat (3) @(negedge sysclk_in);
        for (int i = 0; i < 4; i++) begin
            write_word(vals[i], 1'b1, "full_wr");
            checks++;
            if (fifo_count_out !== 3'(i + 1)) begin
                failures++;
                $display("FAIL full_count: got %0d expected %0d", fifo_count_out, i + 1);
            end
        end
        checks++;
        if (tx_ready_out !== 1'b0) begin
            failures++;
            $display("FAIL full_ready_low: got %b expected 0", tx_ready_out);
        end
        write_word(8'hFF, 1'b0, "full_drop");
        checks++;
        if (fifo_count_out !== 3'd4) begin
            failures++;
            $display("FAIL full_drop_count: got %0d expected 4", fifo_count_out);
        end
        baud_en = 1'b1;
        wait_idle("full_drain");
        checks++;
        if (frames_done - f0 !== 4 || fifo_count_out !== 3'd0) begin
            failures++;
            $display("FAIL full_frames: got frames=%0d count=%0d expected 4 0", frames_done - f0, fifo_count_out);
        end
    endtask

    task automatic test_back_to_back();
        int d0 = done_seen;
        write_word(8'h11, 1'b1, "b2b_first");
        write_word(8'h22, 1'b1, "b2b_second");
        wait_idle("b2b");
        checks++;
        if (done_seen - d0 !== 2) begin
            failures++;
            $display("FAIL b2b_done: got %0d pulses expected 2", done_seen - d0);
        end
    endtask

    task automatic test_reset_midframe();
        int n = 0;
        int f0;
        write_word(8'h96, 1'b1, "rst_first");
        write_word(8'h69, 1'b1, "rst_second");
        while (!(mon_active && mon_k >= 13) && n < 500) begin
            @(negedge sysclk_in);
            n++;
        end
        #2;
        nrst_in = 1'b0;
        #1;
        checks++;
        if (tx_serial_out !== 1'b1 || tx_busy_out !== 1'b0 || tx_done_out !== 1'b0 ||
            tx_ready_out !== 1'b1 || fifo_count_out !== 3'd0 || n >= 500) begin
            failures++;
            $display("FAIL rst_mid_state: got line=%b busy=%b done=%b ready=%b count=%0d expected 1 0 0 1 0",
                     tx_serial_out, tx_busy_out, tx_done_out, tx_ready_out, fifo_count_out);
        end
        repeat (2) @(negedge sysclk_in);
        nrst_in = 1'b1;
        repeat (20) @(negedge sysclk_in);
        f0 = frames_done;
        write_word(8'h3A, 1'b1, "rst_after");
        wait_idle("rst_after");
        checks++;
        if (frames_done - f0 !== 1) begin
            failures++;
            $display("FAIL rst_after_frames: got %0d expected 1", frames_done - f0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_stop2();
        test_fifo_full();
        test_back_to_back();
        test_reset_midframe();
        checks++;
        if (done_seen !== frames_done || sb.size() != 0) begin
            failures++;
            $display("FAIL done_total: got pulses=%0d frames=%0d queued=%0d", done_seen, frames_done, sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
